// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: word width, exponent field and opcodes.
package fpu_pkg;

    localparam int WORD_W = 32;
    localparam int EXP_HI = 30;
    localparam int EXP_LO = 23;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef struct packed {
        fpu_op_e             op;
        logic [WORD_W-1:0]   a;
        logic [WORD_W-1:0]   b;
    } cmd_t;

    // All-ones exponent marks Inf or NaN
    function automatic logic is_exc(input logic [WORD_W-1:0] w);
        return w[EXP_HI:EXP_LO] == '1;
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear; head is shown combinationally.
module fpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Push while full is legal only alongside a pop; the old head is read before the write lands
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/fpu_issue.sv
// Command queue, credit-based issue to a fixed-latency FPU, and in-order result queue.
// Optional FPU_ISSUE_EXC_FLAG_EN stores an Inf/NaN flag with each result on res_exc.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int CDEPTH = 4,
    parameter int RDEPTH = 4,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_a,
    input  logic [WORD_W-1:0] cmd_b,
    input  logic [1:0]        cmd_op,
    input  logic              flush,
    output logic [WORD_W-1:0] fpu_a,
    output logic [WORD_W-1:0] fpu_b,
    output logic [1:0]        fpu_op,
    input  logic [WORD_W-1:0] fpu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic              res_exc,
    output logic              busy
);
    localparam int CCW = $clog2(CDEPTH) + 1;
    localparam int RCW = $clog2(RDEPTH) + 1;
    localparam int FCW = $clog2(LAT + 1);
`ifdef FPU_ISSUE_EXC_FLAG_EN
    localparam int RESW = WORD_W + 1;
`else
    localparam int RESW = WORD_W;
`endif

    cmd_t            cmd_in;
    cmd_t            cmd_head;
    logic [CCW-1:0]  cmd_count;
    logic [RCW-1:0]  res_count;
    logic [RESW-1:0] res_in;
    logic [RESW-1:0] res_head;
    logic [LAT-1:0]  vsr;
    logic [FCW-1:0]  in_flight;
    logic            cmd_push;
    logic            issue;
    logic            res_push;
    logic            res_pop;

    assign cmd_in    = '{op: fpu_op_e'(cmd_op), a: cmd_a, b: cmd_b};
    assign cmd_ready = cmd_count < CCW'(CDEPTH);
    assign cmd_push  = cmd_valid && cmd_ready && !flush;
    assign res_valid = res_count != '0;
    assign res_pop   = res_valid && res_ready;
    assign res_push  = vsr[LAT-1];

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) in_flight = in_flight + FCW'(vsr[i]);
    end

    // A result leaving this edge frees its slot for an issue on the same edge,
    // which keeps full throughput when RDEPTH == LAT + 1.
    assign issue = (cmd_count != '0) && !flush &&
                   ((int'(in_flight) + int'(res_count) - int'(res_pop)) < RDEPTH);

    fpu_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CDEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (cmd_push),
        .din   (cmd_in),
        .pop   (issue),
        .dout  (cmd_head),
        .count (cmd_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a  <= '0;
            fpu_b  <= '0;
            fpu_op <= OP_ADD;
            vsr    <= '0;
        end else begin
            if (issue) begin
                fpu_a  <= cmd_head.a;
                fpu_b  <= cmd_head.b;
                fpu_op <= cmd_head.op;
            end
            vsr <= (vsr << 1) | LAT'(issue);
        end
    end

`ifdef FPU_ISSUE_EXC_FLAG_EN
    assign res_in  = {is_exc(fpu_out), fpu_out};
    assign res_exc = res_valid & res_head[WORD_W];
`else
    assign res_in  = fpu_out;
    assign res_exc = 1'b0;
`endif

    fpu_sync_fifo #(.WIDTH(RESW), .DEPTH(RDEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (res_push),
        .din   (res_in),
        .pop   (res_pop),
        .dout  (res_head),
        .count (res_count)
    );

    assign res_data = res_valid ? res_head[WORD_W-1:0] : '0;
    assign busy     = (cmd_count != '0) || (in_flight != '0) || res_valid;

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue with a fixed-latency FPU stand-in and result scoreboard.
module tb_fpu_issue;
    localparam int CDEPTH = 4;
    localparam int RDEPTH = 4;
    localparam int LAT    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [1:0]  cmd_op;
    logic        flush;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_exc;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int nres     = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] pipe [LAT-1];

    always #5 clk = ~clk;

    fpu_issue #(.CDEPTH(CDEPTH), .RDEPTH(RDEPTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .flush     (flush),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_op    (fpu_op),
        .fpu_out   (fpu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_exc   (res_exc),
        .busy      (busy)
    );

    // External FPU stand-in: known add vectors, otherwise a cheap mixing function
    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (op == 2'b00 && a == 32'h3F49FC44 && b == 32'h3F43A91D) return 32'h3FC6D2B0;
        if (op == 2'b00 && a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
    endfunction

    function automatic logic [32:0] expect_of(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [31:0] d;
        logic        e;
        d = fmodel(a, b, op);
`ifdef FPU_ISSUE_EXC_FLAG_EN
        e = (d[30:23] == 8'hFF);
`else
        e = 1'b0;
`endif
        return {e, d};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= fmodel(fpu_a, fpu_b, fpu_op);
        for (int k = 1; k < LAT-1; k++) pipe[k] <= pipe[k-1];
    end
    assign fpu_out = pipe[LAT-2];

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            checks++;
            nres++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected got=%h exc=%b required=none", res_data, res_exc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({res_exc, res_data} !== mon_e) begin
                    failures++;
                    $display("FAIL result_order got=%b_%h required=%b_%h", res_exc, res_data, mon_e[32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input bit expect_res);
        int n = 0;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout cmd_ready=%b required=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        if (expect_res) exp_q.push_back(expect_of(a, b, op));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin @(posedge clk); #1; n++; end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout busy=%b pending=%0d required=0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks += 8;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b required=1", cmd_ready); end
        if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b required=0", res_valid); end
        if (res_data !== 32'h0) begin failures++; $display("FAIL rst_res_data got=%h required=0", res_data); end
        if (res_exc !== 1'b0)   begin failures++; $display("FAIL rst_res_exc got=%b required=0", res_exc); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
        if (fpu_a !== 32'h0)    begin failures++; $display("FAIL rst_fpu_a got=%h required=0", fpu_a); end
        if (fpu_b !== 32'h0)    begin failures++; $display("FAIL rst_fpu_b got=%h required=0", fpu_b); end
        if (fpu_op !== 2'b00)   begin failures++; $display("FAIL rst_fpu_op got=%b required=00", fpu_op); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single_add();
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 32'h3F49FC44; cmd_b = 32'h3F43A91D; cmd_op = 2'b00;
        exp_q.push_back(expect_of(cmd_a, cmd_b, cmd_op));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b required=1", busy); end
        @(posedge clk); #1;
        checks += 3;
        if (fpu_a !== 32'h3F49FC44) begin failures++; $display("FAIL add_fpu_a got=%h required=3f49fc44", fpu_a); end
        if (fpu_b !== 32'h3F43A91D) begin failures++; $display("FAIL add_fpu_b got=%h required=3f43a91d", fpu_b); end
        if (fpu_op !== 2'b00)       begin failures++; $display("FAIL add_fpu_op got=%b required=00", fpu_op); end
        repeat (LAT-1) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b0) begin failures++; $display("FAIL add_early got=%b required=0", res_valid); end
        end
        @(posedge clk); #1;
        checks += 2;
        if (res_valid !== 1'b1)        begin failures++; $display("FAIL add_latency got=%b required=1", res_valid); end
        if (res_data !== 32'h3FC6D2B0) begin failures++; $display("FAIL add_data got=%h required=3fc6d2b0", res_data); end
        idle(4);
        checks++;
        if (fpu_a !== 32'h3F49FC44) begin failures++; $display("FAIL add_hold got=%h required=3f49fc44", fpu_a); end
        wait_idle(50);
    endtask

    task automatic test_backpressure();
        int n0;
        res_ready = 1'b0;
        n0 = nres;
        for (int i = 0; i < 8; i++) send_cmd(32'h1000_0000 + i, 32'h0003_0000 * i, 2'(i), 1'b1);
        idle(LAT + 2);
        checks += 3;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready got=%b required=0", cmd_ready); end
        if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_res_valid got=%b required=1", res_valid); end
        if (res_data !== exp_q[0][31:0]) begin failures++; $display("FAIL bp_head got=%h required=%h", res_data, exp_q[0][31:0]); end
        idle(3);
        checks++;
        if (res_data !== exp_q[0][31:0]) begin failures++; $display("FAIL bp_stable got=%h required=%h", res_data, exp_q[0][31:0]); end
        res_ready = 1'b1;
        wait_idle(100);
        checks++;
        if (nres - n0 != 8) begin failures++; $display("FAIL bp_count got=%0d required=8", nres - n0); end
    endtask

    task automatic test_back_to_back();
        int first = 0;
        int run   = 1;
        bit seen  = 1'b0;
        res_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [31:0] ra;
                    logic [31:0] rb;
                    ra = $urandom();
                    rb = $urandom();
                    send_cmd(ra, rb, 2'($urandom_range(0, 3)), 1'b1);
                end
            end
            begin
                while (!seen && first < 40) begin
                    @(negedge clk);
                    first++;
                    if (res_valid) seen = 1'b1;
                end
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (res_valid) run++;
                    else break;
                end
            end
        join
        checks += 2;
        if (first != LAT + 3) begin failures++; $display("FAIL stream_latency got=%0d required=%0d", first, LAT + 3); end
        if (run != 16)        begin failures++; $display("FAIL stream_run got=%0d required=16", run); end
        wait_idle(50);
    endtask

    task automatic test_flush();
        int n0;
        res_ready = 1'b0;
        n0 = nres;
        for (int i = 0; i < 3; i++) send_cmd(32'h2000_0000 + i, 32'h0000_0101, 2'b01, 1'b1);
        idle(LAT + 3);
        send_cmd(32'h3000_0001, 32'h0000_0001, 2'b00, 1'b1);
        send_cmd(32'h3000_0002, 32'h0000_0002, 2'b00, 1'b0);
        send_cmd(32'h3000_0003, 32'h0000_0003, 2'b00, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL flush_cmd_ready got=%b required=1", cmd_ready); end
        idle(LAT + 2);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_held got=%b required=1", busy); end
        res_ready = 1'b1;
        wait_idle(100);
        idle(4);
        checks += 2;
        if (nres - n0 != 4) begin failures++; $display("FAIL flush_count got=%0d required=4", nres - n0); end
        if (busy !== 1'b0)  begin failures++; $display("FAIL flush_busy_end got=%b required=0", busy); end
    endtask

    task automatic test_reset_midrun();
        int n0;
        res_ready = 1'b1;
        send_cmd(32'h4000_0001, 32'h0000_0011, 2'b10, 1'b1);
        send_cmd(32'h4000_0002, 32'h0000_0022, 2'b11, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks += 4;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL mrst_res_valid got=%b required=0", res_valid); end
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mrst_cmd_ready got=%b required=1", cmd_ready); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL mrst_busy got=%b required=0", busy); end
        if (fpu_a !== 32'h0)    begin failures++; $display("FAIL mrst_fpu_a got=%h required=0", fpu_a); end
        exp_q.delete();
        n0 = nres;
        idle(2);
        rst = 1'b0;
        idle(LAT + 4);
        checks += 3;
        if (nres != n0)         begin failures++; $display("FAIL mrst_results got=%0d required=0", nres - n0); end
        if (res_valid !== 1'b0) begin failures++; $display("FAIL mrst_after_valid got=%b required=0", res_valid); end
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mrst_after_ready got=%b required=1", cmd_ready); end
    endtask

    task automatic test_exc_flag();
        int n = 0;
        logic exc_req;
`ifdef FPU_ISSUE_EXC_FLAG_EN
        exc_req = 1'b1;
`else
        exc_req = 1'b0;
`endif
        res_ready = 1'b1;
        send_cmd(32'h7F800000, 32'h3F800000, 2'b00, 1'b1);
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks += 2;
        if (res_data !== 32'h7F800000) begin failures++; $display("FAIL exc_data got=%h required=7f800000", res_data); end
        if (res_exc !== exc_req)       begin failures++; $display("FAIL exc_flag got=%b required=%b", res_exc, exc_req); end
        wait_idle(50);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        flush = 1'b0; res_ready = 1'b1;
        test_reset();
        test_single_add();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midrun();
        test_exc_flag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter CDEPTH, default 4, meaning command FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter RDEPTH, default 4, meaning result FIFO depth (power of two, >=2).
REQ-003 SHALL have parameter LAT, default 3, meaning the downstream fpu latency in clk cycles from operand change to valid outp (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_ready, output, 1: command FIFO not full.
REQ-008 SHALL have ports cmd_a and cmd_b, input, 32 each: IEEE-754 single operands.
REQ-009 SHALL have port cmd_op, input, 2: fpu opcode (2'b00 = add).
REQ-010 SHALL have port flush, input, 1: discards all queued, not yet issued commands.
REQ-011 SHALL have ports fpu_a, fpu_b (output, 32) and fpu_op (output, 2): registered drive to the fpu A, B, opcode.
REQ-012 SHALL have port fpu_out, input, 32: the fpu outp.
REQ-013 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, 32), res_exc (output, 1).
REQ-014 SHALL have port busy, output, 1: any command queued, in flight, or result held.

Function
REQ-015 SHALL accept a command on a rising edge with cmd_valid && cmd_ready; cmd_ready = command count < CDEPTH, combinational from state only.
REQ-016 SHALL issue the FIFO head when the FIFO is non-empty and (in_flight + result_count) < RDEPTH, loading fpu_a/fpu_b/fpu_op and popping on the same edge; at most one issue per cycle.
REQ-017 SHALL hold fpu_a/fpu_b/fpu_op unchanged on cycles without issue.
REQ-018 SHALL track issues with a LAT-stage valid shift register; when the stage-LAT bit is set, SHALL push fpu_out into the result FIFO on that edge.
REQ-019 SHALL produce res_valid LAT+1 cycles after the accepting edge when all queues are empty (accept edge E0, issue E1, capture E1+LAT).
REQ-020 SHALL sustain one command accepted, one issued, one result retired per cycle in steady state with res_ready high.
REQ-021 SHALL pop a result on res_valid && res_ready; res_data/res_exc SHALL be stable while res_valid && !res_ready.
REQ-022 SHALL never overflow the result FIFO: credit rule of REQ-016 counts in-flight issues; a capture and a pop on the same edge leave result_count unchanged.
REQ-023 SHALL, on simultaneous accept and issue with the FIFO full, not accept (cmd_ready is low when full).
REQ-024 SHALL, on flush, empty the command FIFO and suppress accept and issue that cycle; in-flight and held results SHALL complete normally.
REQ-025 SHALL preserve command order: results emerge in acceptance order.
REQ-026 SHALL assert busy = (cmd_count != 0) || (in_flight != 0) || res_valid.

Reset
REQ-027 SHALL, while rst is high, clear FIFO pointers/counts, the valid shift register, fpu_a/fpu_b to 32'h0, fpu_op to 2'b00; cmd_ready=1, res_valid=0, res_data=0, res_exc=0, busy=0.
REQ-028 SHALL discard all in-flight work on reset mid-operation; no result produced from pre-reset issues.

Configuration
REQ-029 SHALL, with FPU_ISSUE_EXC_FLAG_EN defined, set res_exc per result = (res_data[30:23] == 8'hFF) (Inf/NaN), stored alongside data in the result FIFO.
REQ-030 SHALL, without FPU_ISSUE_EXC_FLAG_EN, keep the res_exc port, tie it to 0, and store no flag bit.

Structure
REQ-031 SHALL place opcode constants (OP_ADD=2'b00 etc.), the 32-bit word width, and the exponent field range in shared package fpu_pkg.
REQ-032 SHALL implement both queues with one sub-module, fpu_sync_fifo (parameterised width and depth, count output).

Verification
REQ-033 Single add: cmd a=32'h3F49FC44, b=32'h3F43A91D, op=00 at edge 0 -> fpu_a/fpu_b loaded edge 1; res_valid at edge 1+LAT with res_data=32'h3FC6D2B0.
REQ-034 Back-pressure: res_ready=0, push 8 commands -> exactly RDEPTH results held, cmd_ready low after CDEPTH further queued; release res_ready -> 8 results in order, none lost.
REQ-035 Streaming: 16 back-to-back commands, res_ready=1 -> one result per cycle after LAT+1 fill, in order.
REQ-036 Flush: queue 3, flush while 1 in flight -> exactly 1 result, busy falls after it retires.
REQ-037 Reset mid-run: assert rst with 2 in flight -> res_valid=0 immediately, no results after release, cmd_ready=1.
REQ-038 Exception flag: a=32'h7F800000, b=32'h3F800000, op=00 -> res_data=32'h7F800000, res_exc=1 with macro, 0 without.
